// File: rtl/alu_pkg.sv
// Shared opcode, response-error and FSM state definitions for the ALU issue controller.
package alu_pkg;

    // ALU opcodes; anything above OP_DIV is illegal on the request side
    localparam logic [4:0] OP_OR   = 5'd0;
    localparam logic [4:0] OP_AND  = 5'd1;
    localparam logic [4:0] OP_ADD  = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_ADDU = 5'd4;
    localparam logic [4:0] OP_MUL  = 5'd5;
    localparam logic [4:0] OP_DIV  = 5'd6;
    localparam logic [4:0] OP_NOP  = 5'd31;

    // Response error codes
    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // Latency / timeout counter width, shared by the comb wait and the divide wait
    localparam int CNT_W = 7;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_COMB = 3'd2,
        S_WAIT_DIV  = 3'd3,
        S_CAPTURE   = 3'd4,
        S_RESP      = 3'd5
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue controller sitting between a request/response handshake and a registered ALU.
// Fixed-latency ops wait COMB_LAT cycles; DIV waits for div_done with a timeout.
// Illegal ops and divide-by-zero are answered locally without touching the ALU.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COMB_LAT    = 2,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DATA_WIDTH-1:0]   req_a,
    input  logic [DATA_WIDTH-1:0]   req_b,
    input  logic [4:0]              req_op,
    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    output logic [4:0]              alu_op,
    input  logic [2*DATA_WIDTH-1:0] alu_result,
    input  logic                    div_done,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_hi,
    output logic [DATA_WIDTH-1:0]   rsp_lo,
    output logic [1:0]              rsp_err
);

    localparam logic [CNT_W-1:0] COMB_LOAD = CNT_W'(COMB_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [4:0]              alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0]   rsp_hi_q, rsp_hi_d, rsp_lo_q, rsp_lo_d;
    logic [1:0]              rsp_err_q, rsp_err_d;
    // Error decided at accept time; ISSUE either forwards it or starts the divide wait.
    // Routing errors through ISSUE gives them the same two-cycle turnaround as a divide issue.
    logic [1:0]              err_pend_q, err_pend_d;
    logic                    req_ready_q, rsp_valid_q;

    // Next-state and datapath decode for the issue FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rsp_hi_d   = rsp_hi_q;
        rsp_lo_d   = rsp_lo_q;
        rsp_err_d  = rsp_err_q;
        err_pend_d = err_pend_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_op <= OP_MUL) begin
                        alu_a_d  = req_a;
                        alu_b_d  = req_b;
                        alu_op_d = req_op;
                        cnt_d    = COMB_LOAD;
                        state_d  = S_WAIT_COMB;
                    end else if (req_op == OP_DIV && req_b != '0) begin
                        alu_a_d    = req_a;
                        alu_b_d    = req_b;
                        alu_op_d   = OP_DIV;
                        err_pend_d = ERR_OK;
                        state_d    = S_ISSUE;
                    end else begin
                        err_pend_d = (req_op == OP_DIV) ? ERR_DIV0 : ERR_ILLEGAL;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (err_pend_q != ERR_OK) begin
                    rsp_hi_d  = '0;
                    rsp_lo_d  = '0;
                    rsp_err_d = err_pend_q;
                    state_d   = S_RESP;
                end else begin
                    cnt_d   = DIV_LOAD;
                    state_d = S_WAIT_DIV;
                end
            end
            S_WAIT_COMB: begin
                if (cnt_q == '0) state_d = S_CAPTURE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WAIT_DIV: begin
                // div_done wins over an expiring counter in the same cycle
                if (div_done) begin
                    state_d = S_CAPTURE;
                end else if (cnt_q == '0) begin
                    alu_op_d  = OP_NOP;
                    rsp_hi_d  = '0;
                    rsp_lo_d  = '0;
                    rsp_err_d = ERR_TIMEOUT;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CAPTURE: begin
                rsp_hi_d  = alu_result[2*DATA_WIDTH-1:DATA_WIDTH];
                rsp_lo_d  = alu_result[DATA_WIDTH-1:0];
                rsp_err_d = ERR_OK;
                alu_op_d  = OP_NOP;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_NOP;
            rsp_hi_q    <= '0;
            rsp_lo_q    <= '0;
            rsp_err_q   <= ERR_OK;
            err_pend_q  <= ERR_OK;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_err_q   <= rsp_err_d;
            err_pend_q  <= err_pend_d;
            req_ready_q <= (state_d == S_IDLE);
            rsp_valid_q <= (state_d == S_RESP);
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_hi    = rsp_hi_q;
    assign rsp_lo    = rsp_lo_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: registered ALU model, directed cases, then random
// transactions checked against an arithmetic reference of the expected response.
module tb_alu_issue_ctrl;

    localparam int DW          = 32;
    localparam int COMB_LAT    = 2;
    localparam int DIV_TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_a = '0, req_b = '0;
    logic [4:0]    req_op = '0;
    logic [DW-1:0] alu_a, alu_b;
    logic [4:0]    alu_op;
    logic [2*DW-1:0] alu_result = '0;
    logic          div_done = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_hi, rsp_lo;
    logic [1:0]    rsp_err;

    int ntests = 0;
    int nfail  = 0;

    alu_issue_ctrl #(.DATA_WIDTH(DW), .COMB_LAT(COMB_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .div_done(div_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Arithmetic the ALU performs for the fixed-latency ops
    function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            5'd0:    return {32'd0, a | b};
            5'd1:    return {32'd0, a & b};
            5'd2:    return {32'd0, a} + {32'd0, b};
            5'd3:    return sa - sb;
            5'd4:    return {32'd0, a} + {32'd0, b};
            5'd5:    return sa * sb;
            default: return 64'd0;
        endcase
    endfunction

    // Registered ALU: comb ops update every cycle, the divider lands its result with div_done
    always @(posedge clk) begin
        if (alu_op <= 5'd5)
            alu_result <= alu_fn(alu_op, alu_a, alu_b);
        else if (alu_op == 5'd6 && div_done && alu_b != 0)
            alu_result <= {alu_a % alu_b, alu_a / alu_b};
    end

    // Expected response of one transaction. d = cycles from issue to div_done (0 = never).
    function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                      input int d, output logic [1:0] err, output logic [63:0] data,
                                      output int lat, output logic [4:0] aop);
        if (op <= 5'd5) begin
            err = 2'b00; data = alu_fn(op, a, b); lat = COMB_LAT + 2; aop = op;
        end else if (op == 5'd6 && b != 0) begin
            aop = 5'd6;
            if (d >= 1 && d <= DIV_TIMEOUT) begin
                err = 2'b00; data = {a % b, a / b}; lat = d + 3;
            end else begin
                err = 2'b11; data = 64'd0; lat = DIV_TIMEOUT + 2;
            end
        end else begin
            aop = 5'd31; err = (op == 5'd6) ? 2'b01 : 2'b10; data = 64'd0; lat = 2;
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, {rsp_hi, rsp_lo}, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_alu_ab"}, {alu_a, alu_b}, 0);
        chk({tag, "_alu_op"}, alu_op, 31);
    endtask

    // One full request/response; latency counted in cycles from the accept cycle
    task automatic run_txn(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int d, input int hold);
        logic [1:0]  e_err;
        logic [63:0] e_data;
        int          e_lat;
        logic [4:0]  e_op;
        int          lat;
        bit          ok_op, ok_hold;
        logic [65:0] snap;
        ref_model(op, a, b, d, e_err, e_data, e_lat, e_op);
        @(negedge clk);
        chk({tag, "_ready"}, req_ready, 1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_op = 5'($urandom); req_a = $urandom; req_b = $urandom;
        lat = 1; ok_op = 1'b1;
        while (rsp_valid !== 1'b1 && lat < 300) begin
            if (alu_op !== e_op || req_ready !== 1'b0) ok_op = 1'b0;
            div_done  = (d != 0 && lat == d + 1);
            req_valid = 1'($urandom_range(0, 1));
            rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        div_done = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'(e_lat));
        chk({tag, "_err"}, rsp_err, e_err);
        chk({tag, "_hi"}, rsp_hi, e_data[63:32]);
        chk({tag, "_lo"}, rsp_lo, e_data[31:0]);
        chk({tag, "_alu_op_busy"}, ok_op, 1);
        chk({tag, "_alu_op_after"}, alu_op, 31);
        snap = {rsp_hi, rsp_lo, rsp_err}; ok_hold = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if ({rsp_hi, rsp_lo, rsp_err} !== snap || rsp_valid !== 1'b1 || req_ready !== 1'b0)
                ok_hold = 1'b0;
        end
        chk({tag, "_hold"}, ok_hold, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_idle_after"}, {rsp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b;
        int          d, sel;

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("post_reset");

        // Directed cases
        run_txn("add", 5'd2, 32'd5, 32'd7, 0, 0);
        run_txn("mul", 5'd5, 32'hFFFF_FFFF, 32'd2, 0, 0);
        chk("mul_const", {rsp_hi, rsp_lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_txn("div", 5'd6, 32'd100, 32'd7, 33, 0);
        run_txn("div0", 5'd6, 32'd100, 32'd0, 3, 0);
        run_txn("illegal", 5'd9, 32'd1, 32'd2, 0, 0);
        run_txn("timeout", 5'd6, 32'd9, 32'd3, 0, 0);
        run_txn("backpressure", 5'd3, 32'd3, 32'd10, 0, 10);
        run_txn("div_last", 5'd6, 32'hDEAD_BEEF, 32'd77, DIV_TIMEOUT, 2);

        // Reset in WAIT_DIV: outputs return to reset values without waiting for a clock edge
        @(negedge clk);
        req_valid = 1'b1; req_op = 5'd6; req_a = 32'd50; req_b = 32'd5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_div_op", alu_op, 6);
        #2 reset = 1'b1;
        #1 chk_reset_vals("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("after_mid_reset");

        // Random transactions
        for (int t = 0; t < 30; t++) begin
            sel = $urandom_range(0, 9);
            a = $urandom; b = $urandom;
            d = $urandom_range(0, 5);
            if (sel <= 5) op = 5'(sel);
            else if (sel <= 7) begin
                op = 5'd6;
                b  = (b == 0) ? 32'd1 : b >> $urandom_range(0, 31);
                d  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 60);
            end else if (sel == 8) begin
                op = 5'd6; b = 32'd0;
            end else op = 5'($urandom_range(7, 31));
            run_txn("rand", op, a, b, d, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
